// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared screen geometry, colours and checker state encoding
package maze_pkg;

    localparam int SCREEN_W = 96;
    localparam int SCREEN_H = 64;
    localparam int INDEX_W  = 13;
    localparam int X_W      = 7;
    localparam int Y_W      = 6;
    localparam int CNT_W    = 4;

    localparam logic [15:0] WALL_COLOR = 16'hFFFF;
    localparam logic [15:0] GOAL_COLOR = 16'h001F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } chk_state_t;

endpackage

// File: rtl/maze_scan_addr.sv
// rtl/maze_scan_addr.sv - sprite footprint walker: dx/dy counters, bounds check, pixel index
module maze_scan_addr
    import maze_pkg::*;
#(
    parameter int SPR_W = 3,
    parameter int SPR_H = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               step,
    input  logic [X_W-1:0]     x_pos,
    input  logic [Y_W-1:0]     y_pos,
    output logic [INDEX_W-1:0] index,
    output logic               off_screen,
    output logic               last
);

    localparam logic [CNT_W-1:0] DX_LAST = CNT_W'(SPR_W - 1);
    localparam logic [CNT_W-1:0] DY_LAST = CNT_W'(SPR_H - 1);

    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [CNT_W-1:0] dx;
    logic [CNT_W-1:0] dy;
    logic [X_W:0]     x_sum;
    logic [Y_W:0]     y_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
            dx  <= '0;
            dy  <= '0;
        end else if (start) begin
            x_q <= x_pos;
            y_q <= y_pos;
            dx  <= '0;
            dy  <= '0;
        end else if (step) begin
            if (dx == DX_LAST) begin
                dx <= '0;
                dy <= dy + 1'b1;
            end else begin
                dx <= dx + 1'b1;
            end
        end
    end

    // Sums carry one extra bit so right/bottom overrun is detected, not wrapped.
    assign x_sum      = {1'b0, x_q} + {{(X_W + 1 - CNT_W){1'b0}}, dx};
    assign y_sum      = {1'b0, y_q} + {{(Y_W + 1 - CNT_W){1'b0}}, dy};
    assign off_screen = (x_sum >= (X_W + 1)'(SCREEN_W)) || (y_sum >= (Y_W + 1)'(SCREEN_H));
    assign index      = INDEX_W'(y_sum[Y_W-1:0]) * INDEX_W'(SCREEN_W) + INDEX_W'(x_sum[X_W-1:0]);
    assign last       = (dx == DX_LAST) && (dy == DY_LAST);

endmodule

// File: rtl/maze_collision_checker.sv
// rtl/maze_collision_checker.sv - scans sprite footprint against maze ROM, reports wall/goal hits
module maze_collision_checker #(
    parameter int          SPR_W      = 3,
    parameter int          SPR_H      = 3,
    parameter logic [15:0] WALL_COLOR = maze_pkg::WALL_COLOR,
    parameter logic [15:0] GOAL_COLOR = maze_pkg::GOAL_COLOR
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req,
    input  logic [maze_pkg::X_W-1:0]     x_pos,
    input  logic [maze_pkg::Y_W-1:0]     y_pos,
    output logic [maze_pkg::INDEX_W-1:0] maze_index,
    input  logic [15:0]                  maze_data,
    output logic                         busy,
    output logic                         done,
    output logic                         hit_wall,
    output logic                         hit_goal
);
    import maze_pkg::*;

    chk_state_t         state;
    logic               issuing;
    logic               iss_valid;
    logic               iss_off;
    logic               tag_valid;
    logic               tag_off;
    logic               start;
    logic               step;
    logic [INDEX_W-1:0] scan_index;
    logic               scan_off;
    logic               scan_last;

    assign start = (state == ST_IDLE) && req;
    assign step  = (state == ST_SCAN) && issuing && !scan_last;

    maze_scan_addr #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_addr (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .step       (step),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .index      (scan_index),
        .off_screen (scan_off),
        .last       (scan_last)
    );

    // iss_* describes the pixel on maze_index; tag_* lines up with maze_data one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            maze_index <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hit_wall   <= 1'b0;
            hit_goal   <= 1'b0;
            issuing    <= 1'b0;
            iss_valid  <= 1'b0;
            iss_off    <= 1'b0;
            tag_valid  <= 1'b0;
            tag_off    <= 1'b0;
        end else begin
            tag_valid <= iss_valid;
            tag_off   <= iss_off;
            if (tag_valid) begin
                if (tag_off || maze_data == WALL_COLOR) hit_wall <= 1'b1;
                if (!tag_off && maze_data == GOAL_COLOR) hit_goal <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state     <= ST_SCAN;
                        busy      <= 1'b1;
                        issuing   <= 1'b1;
                        hit_wall  <= 1'b0;
                        hit_goal  <= 1'b0;
                        iss_valid <= 1'b0;
                        tag_valid <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (issuing) begin
                        iss_valid <= 1'b1;
                        iss_off   <= scan_off;
                        if (!scan_off) maze_index <= scan_index;
                        if (scan_last) issuing <= 1'b0;
                    end else begin
                        iss_valid <= 1'b0;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_collision_checker.sv
// tb/tb_maze_collision_checker.sv - self-checking bench with footprint model and level-8 maze ROM
module tb_maze_collision_checker;

    localparam int N = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [6:0]  x_pos;
    logic [5:0]  y_pos;
    logic [12:0] maze_index;
    logic [15:0] maze_data = 16'h0;
    logic        busy;
    logic        done;
    logic        hit_wall;
    logic        hit_goal;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [15:0] rom [0:6143];

    maze_collision_checker dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .maze_index (maze_index),
        .maze_data  (maze_data),
        .busy       (busy),
        .done       (done),
        .hit_wall   (hit_wall),
        .hit_goal   (hit_goal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] color_at(input int x, input int y);
        if (x >= 72 && x <= 80 && y >= 40 && y <= 48) return 16'h001F;
        if (x >= 81 && x <= 83 && y >= 40 && y <= 50) return 16'hFFFF;
        if (x <= 2 || x >= 93 || y >= 61) return 16'hFFFF;
        if (y <= 2 && !(x >= 83 && x <= 92)) return 16'hFFFF;
        if (x >= 20 && x <= 25 && y >= 20 && y <= 25) return 16'h07E0;
        return 16'h0000;
    endfunction

    function automatic bit fp_wall(input int x, input int y);
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) begin
                if (x + dx >= 96 || y + dy >= 64) return 1'b1;
                if (color_at(x + dx, y + dy) == 16'hFFFF) return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic bit fp_goal(input int x, input int y);
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                if (x + dx < 96 && y + dy < 64 && color_at(x + dx, y + dy) == 16'h001F) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int fp_last(input int x, input int y, input int prev);
        int r = prev;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                if (x + dx < 96 && y + dy < 64) r = (y + dy) * 96 + x + dx;
        return r;
    endfunction

    function automatic bit fp_allows(input int idx, input int x, input int y, input int base);
        if (idx == base) return 1'b1;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                if (x + dx < 96 && y + dy < 64 && idx == (y + dy) * 96 + x + dx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 96; x++)
                rom[y * 96 + x] = color_at(x, y);
    end

    always @(posedge clk) maze_data <= (maze_index < 13'd6144) ? rom[maze_index] : 16'h0;

    // Reference model: fixed-latency transaction view of a scan.
    bit m_busy = 0, m_done = 0, m_wall = 0, m_goal = 0, f_wall = 0, f_goal = 0;
    int m_cnt = 0, m_x = 0, m_y = 0, m_base = 0, m_prev = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 0; m_done <= 0; m_wall <= 0; m_goal <= 0;
            m_cnt <= 0; m_prev <= 0; m_base <= 0;
        end else if (!m_busy) begin
            if (req) begin
                m_busy <= 1; m_cnt <= 0; m_wall <= 0; m_goal <= 0;
                m_x <= int'(x_pos); m_y <= int'(y_pos);
                f_wall <= fp_wall(int'(x_pos), int'(y_pos));
                f_goal <= fp_goal(int'(x_pos), int'(y_pos));
                m_base <= m_prev;
                m_prev <= fp_last(int'(x_pos), int'(y_pos), m_prev);
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == N + 2) begin
                m_done <= 1; m_wall <= f_wall; m_goal <= f_goal;
            end
            if (m_cnt + 1 == N + 3) begin
                m_done <= 0; m_busy <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("busy", int'(busy), int'(m_busy));
            check("done", int'(done), int'(m_done));
            if (!m_busy || m_cnt == 0 || m_done) begin
                check("hit_wall", int'(hit_wall), int'(m_wall));
                check("hit_goal", int'(hit_goal), int'(m_goal));
            end
            if (m_busy)
                check("maze_index_in_footprint", int'(fp_allows(int'(maze_index), m_x, m_y, m_base)), 1);
            else
                check("maze_index_idle", int'(maze_index), m_prev);
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic run_scan(input int x, input int y, input bit ew, input bit eg, input string name);
        int e0;
        bit seen = 0;
        @(negedge clk);
        x_pos = 7'(x); y_pos = 6'(y); req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        e0 = cyc;
        for (int t = 0; t < 40 && !seen; t++) begin
            if (done) seen = 1;
            else @(negedge clk);
        end
        check({name, "_latency"}, seen ? cyc - e0 : -1, N + 2);
        if (seen) begin
            check({name, "_wall"}, int'(hit_wall), int'(ew));
            check({name, "_goal"}, int'(hit_goal), int'(eg));
        end
        wait_idle();
    endtask

    initial begin
        int d1, d2, ndone;
        bit seen;
        reset = 1'b1; req = 1'b0; x_pos = '0; y_pos = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_flags", int'({hit_wall, hit_goal}), 0);
        check("reset_index", int'(maze_index), 0);
        reset = 1'b0;

        run_scan(5, 5, 0, 0, "open_floor");
        run_scan(1, 5, 1, 0, "left_border");
        run_scan(74, 42, 0, 1, "goal_region");
        run_scan(95, 10, 1, 0, "right_offscreen");
        run_scan(85, 1, 0, 0, "top_entrance");
        run_scan(79, 47, 1, 1, "wall_and_goal");
        run_scan(20, 20, 0, 0, "other_colour");
        check("index_after_green", int'(maze_index), 22 * 96 + 22);

        // req while busy is ignored
        @(negedge clk);
        x_pos = 7'd5; y_pos = 6'd5; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        ndone = 0;
        for (int t = 0; t < 30; t++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("busy_req_single_done", ndone, 1);

        // req held high: back-to-back scans
        x_pos = 7'd5; y_pos = 6'd5; req = 1'b1;
        d1 = -1; d2 = -1; seen = 0;
        for (int t = 0; t < 60 && d2 < 0; t++) begin
            @(negedge clk);
            if (done && !seen) begin
                if (d1 < 0) d1 = cyc; else d2 = cyc;
                seen = 1;
            end else if (!done) begin
                seen = 0;
            end
        end
        req = 1'b0;
        check("held_req_done_gap", (d1 >= 0 && d2 >= 0) ? d2 - d1 : -1, N + 4);
        wait_idle();

        // reset mid-scan aborts
        @(negedge clk);
        x_pos = 7'd1; y_pos = 6'd5; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_flags", int'({hit_wall, hit_goal}), 0);
        check("abort_index", int'(maze_index), 0);
        ndone = 0;
        for (int t = 0; t < 20; t++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort_no_done", ndone, 0);

        run_scan(74, 42, 0, 1, "post_abort_goal");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
